// File: rtl/data_mem_ctrl_if.sv
// Request/response bus between a load/store unit and data_mem_ctrl.
// Handshake: the master holds req with we/funct3/addr/wdata stable; the request is taken
// on a rising edge where req=1 and ready=1. Exactly one done pulse follows, carrying err and rdata.
interface data_mem_ctrl_if #(
    parameter int ADDR_W = 8
);
    logic              req;
    logic              we;
    logic [2:0]        funct3;
    logic [ADDR_W-1:0] addr;
    logic [31:0]       wdata;
    logic              ready;
    logic              done;
    logic [31:0]       rdata;
    logic              err;

    modport master (
        output req, we, funct3, addr, wdata,
        input  ready, done, rdata, err
    );

    modport slave (
        input  req, we, funct3, addr, wdata,
        output ready, done, rdata, err
    );
endinterface

// File: rtl/data_mem_ctrl.sv
// Byte-addressed 32-bit data memory with RV32I load/store sizing and LAT wait cycles.
// Each request completes with one done pulse; illegal requests complete early with err=1.
module data_mem_ctrl #(
    parameter int DEPTH  = 64,
    parameter int ADDR_W = 8,
    parameter int LAT    = 1
) (
    input  logic                clk,
    input  logic                rst,
    data_mem_ctrl_if.slave      bus,
    output logic [1:0]          dbg_state
);
    localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t            state, state_n;
    logic [2:0]        cnt, cnt_n;
    logic              we_q;
    logic [2:0]        f3_q;
    logic [ADDR_W-1:0] addr_q;
    logic [31:0]       wdata_q;
    logic [31:0]       rdata_q;
    logic              err_q;
    logic              accept, commit;

    logic [31:0] mem [DEPTH] = '{default: 32'h0};

    // In IDLE the live bus is the operation (needed when LAT=0); afterwards the latched copy is.
    logic              cur_we;
    logic [2:0]        cur_f3;
    logic [ADDR_W-1:0] cur_addr;
    logic [31:0]       cur_wdata;
    logic [IW-1:0]     idx;
    logic [31:0]       idx_full;
    logic              bad;

    assign cur_we    = (state == IDLE) ? bus.we     : we_q;
    assign cur_f3    = (state == IDLE) ? bus.funct3 : f3_q;
    assign cur_addr  = (state == IDLE) ? bus.addr   : addr_q;
    assign cur_wdata = (state == IDLE) ? bus.wdata  : wdata_q;
    assign idx       = cur_addr[2 +: IW];
    assign idx_full  = 32'(cur_addr[ADDR_W-1:2]);

    always_comb begin
        logic misal, illegal;
        misal   = (((cur_f3 == 3'd1) || (cur_f3 == 3'd5)) && cur_addr[0]) ||
                  ((cur_f3 == 3'd2) && (cur_addr[1:0] != 2'b00));
        illegal = cur_we ? (cur_f3 > 3'd2)
                         : ((cur_f3 == 3'd3) || (cur_f3 == 3'd6) || (cur_f3 == 3'd7));
        bad     = misal || illegal || (idx_full >= 32'(DEPTH));
    end

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        accept  = 1'b0;
        commit  = 1'b0;
        case (state)
            IDLE: begin
                if (bus.req) begin
                    accept = 1'b1;
                    if (bad) begin
                        state_n = DONE;
                    end else if (LAT == 0) begin
                        state_n = DONE;
                        commit  = 1'b1;
                    end else begin
                        state_n = WAIT;
                        cnt_n   = 3'(LAT);
                    end
                end
            end
            WAIT: begin
                cnt_n = cnt - 3'd1;
                if (cnt <= 3'd1) begin
                    state_n = DONE;
                    commit  = 1'b1;
                end
            end
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    logic [31:0] word, load_val, store_val;
    logic [7:0]  bsel;
    logic [15:0] hsel;
    logic [3:0]  be;

    assign word = mem[idx];
    assign bsel = word[8*cur_addr[1:0] +: 8];
    assign hsel = cur_addr[1] ? word[31:16] : word[15:0];

    always_comb begin
        case (cur_f3)
            3'd0:    load_val = {{24{bsel[7]}}, bsel};
            3'd1:    load_val = {{16{hsel[15]}}, hsel};
            3'd4:    load_val = {24'h0, bsel};
            3'd5:    load_val = {16'h0, hsel};
            default: load_val = word;
        endcase
    end

    // Narrow stores replicate their data across the word; be picks the lanes that land.
    always_comb begin
        case (cur_f3)
            3'd0: begin
                be        = 4'b0001 << cur_addr[1:0];
                store_val = {4{cur_wdata[7:0]}};
            end
            3'd1: begin
                be        = cur_addr[1] ? 4'b1100 : 4'b0011;
                store_val = {2{cur_wdata[15:0]}};
            end
            default: begin
                be        = 4'b1111;
                store_val = cur_wdata;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            cnt     <= 3'd0;
            we_q    <= 1'b0;
            f3_q    <= 3'd0;
            addr_q  <= '0;
            wdata_q <= 32'h0;
            rdata_q <= 32'h0;
            err_q   <= 1'b0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            if (accept) begin
                we_q    <= bus.we;
                f3_q    <= bus.funct3;
                addr_q  <= bus.addr;
                wdata_q <= bus.wdata;
            end
            if (accept && bad) begin
                err_q <= 1'b1;
            end else if (commit) begin
                err_q <= 1'b0;
            end
            if (commit && !cur_we) begin
                rdata_q <= load_val;
            end
        end
    end

    // The array is deliberately outside the reset domain.
    always_ff @(posedge clk) begin
        if (!rst && commit && cur_we) begin
            for (int b = 0; b < 4; b++) begin
                if (be[b]) mem[idx][8*b +: 8] <= store_val[8*b +: 8];
            end
        end
    end

    assign bus.ready = (state == IDLE);
    assign bus.done  = (state == DONE);
    assign bus.rdata = rdata_q;
    assign bus.err   = err_q;
    assign dbg_state = state;
endmodule
